ctrl_pipe_regs: RTL and testbench

- Consumer end of the decode interface: takes the 8-bit control bundle plus Branch/Jump produced in ID and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Distributes the EX, MEM and WB control fields to their stages.
- Also owns load-use hazard detection (stall, bubble insertion) and branch/jump flush of the control path.

---
 rtl/ctrl_pipe_regs.sv | 205 ++++++++++++++++++++
 tb/tb_ctrl_pipe_regs.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_regs
// Brief    : ID/EX, EX/MEM and MEM/WB control pipeline registers with
//            load-use stall detection and branch/jump flush of the control
//            path. Optional performance counters are enabled by defining
//            CTRL_PIPE_PERF_EN (adds stall_cnt / flush_cnt outputs).
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_regs #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [7:0]      id_ctrl,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            ex_redirect,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            ex_reg_dst,
  output logic [1:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [RA_W-1:0] ex_wr_reg,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_reg_write,
  output logic            mem_mem_to_reg,
  output logic [RA_W-1:0] mem_wr_reg,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic [RA_W-1:0] wb_wr_reg
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Elaboration-time sanity check on the counter width.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("ctrl_pipe_regs: CNT_W must be at least 1");
  end

  // ID/EX stage state
  logic            idex_reg_dst_q,  idex_reg_dst_d;
  logic [1:0]      idex_alu_op_q,   idex_alu_op_d;
  logic            idex_alu_src_q,  idex_alu_src_d;
  logic            idex_mem_read_q, idex_mem_read_d;
  logic            idex_mem_wr_q,   idex_mem_wr_d;
  logic            idex_reg_wr_q,   idex_reg_wr_d;
  logic            idex_m2r_q,      idex_m2r_d;
  logic            idex_branch_q,   idex_branch_d;
  logic            idex_jump_q,     idex_jump_d;
  logic [RA_W-1:0] idex_rt_q,       idex_rt_d;
  logic [RA_W-1:0] idex_rd_q,       idex_rd_d;

  // EX/MEM stage state
  logic            exmem_mem_read_q, exmem_mem_wr_q, exmem_reg_wr_q, exmem_m2r_q;
  logic [RA_W-1:0] exmem_wr_reg_q;

  // MEM/WB stage state
  logic            memwb_reg_wr_q, memwb_m2r_q;
  logic [RA_W-1:0] memwb_wr_reg_q;

  logic w_load_use;
  logic w_idex_bubble;
  logic w_ex_wr_nz;

  // Hazard detection and ID/EX next-state selection (redirect > load-use > normal).
  always_comb begin
    w_load_use = idex_mem_read_q & id_valid & ~id_jump & (idex_rt_q != '0)
               & ((idex_rt_q == id_rs) | (idex_rt_q == id_rt));
    w_idex_bubble = ex_redirect | w_load_use | ~id_valid;

    pc_write   = ex_redirect | ~w_load_use;
    ifid_write = ex_redirect | ~w_load_use;
    ifid_flush = ex_redirect;

    // Bubble first; fields only overwritten for a real, unstalled instruction.
    // RegDst and MemtoReg are meaningless without RegWrite, so they are
    // AND-gated with it; this also keeps undriven decode bits out of EX.
    idex_reg_dst_d  = 1'b0;
    idex_alu_op_d   = 2'b00;
    idex_alu_src_d  = 1'b0;
    idex_mem_read_d = 1'b0;
    idex_mem_wr_d   = 1'b0;
    idex_reg_wr_d   = 1'b0;
    idex_m2r_d      = 1'b0;
    idex_branch_d   = 1'b0;
    idex_jump_d     = 1'b0;
    idex_rt_d       = '0;
    idex_rd_d       = '0;
    if (!w_idex_bubble) begin
      idex_reg_dst_d  = id_ctrl[7] & id_ctrl[1];
      idex_alu_op_d   = id_ctrl[6:5];
      idex_alu_src_d  = id_ctrl[4];
      idex_mem_read_d = id_ctrl[3];
      idex_mem_wr_d   = id_ctrl[2];
      idex_reg_wr_d   = id_ctrl[1];
      idex_m2r_d      = id_ctrl[0] & id_ctrl[1];
      idex_branch_d   = id_branch;
      idex_jump_d     = id_jump;
      idex_rt_d       = id_rt;
      // rd is only meaningful when RegDst selects it.
      idex_rd_d       = (id_ctrl[7] & id_ctrl[1]) ? id_rd : '0;
    end
  end

  // Write-register select in EX and $0 detection for write suppression.
  always_comb begin
    ex_wr_reg  = idex_reg_dst_q ? idex_rd_q : idex_rt_q;
    w_ex_wr_nz = (ex_wr_reg != '0);
  end

  // All three stage registers; EX/MEM and MEM/WB advance every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_reg_dst_q   <= 1'b0;
      idex_alu_op_q    <= 2'b00;
      idex_alu_src_q   <= 1'b0;
      idex_mem_read_q  <= 1'b0;
      idex_mem_wr_q    <= 1'b0;
      idex_reg_wr_q    <= 1'b0;
      idex_m2r_q       <= 1'b0;
      idex_branch_q    <= 1'b0;
      idex_jump_q      <= 1'b0;
      idex_rt_q        <= '0;
      idex_rd_q        <= '0;
      exmem_mem_read_q <= 1'b0;
      exmem_mem_wr_q   <= 1'b0;
      exmem_reg_wr_q   <= 1'b0;
      exmem_m2r_q      <= 1'b0;
      exmem_wr_reg_q   <= '0;
      memwb_reg_wr_q   <= 1'b0;
      memwb_m2r_q      <= 1'b0;
      memwb_wr_reg_q   <= '0;
    end else begin
      idex_reg_dst_q   <= idex_reg_dst_d;
      idex_alu_op_q    <= idex_alu_op_d;
      idex_alu_src_q   <= idex_alu_src_d;
      idex_mem_read_q  <= idex_mem_read_d;
      idex_mem_wr_q    <= idex_mem_wr_d;
      idex_reg_wr_q    <= idex_reg_wr_d;
      idex_m2r_q       <= idex_m2r_d;
      idex_branch_q    <= idex_branch_d;
      idex_jump_q      <= idex_jump_d;
      idex_rt_q        <= idex_rt_d;
      idex_rd_q        <= idex_rd_d;
      exmem_mem_read_q <= idex_mem_read_q;
      exmem_mem_wr_q   <= idex_mem_wr_q;
      exmem_reg_wr_q   <= idex_reg_wr_q & w_ex_wr_nz;
      exmem_m2r_q      <= idex_m2r_q & w_ex_wr_nz;
      exmem_wr_reg_q   <= ex_wr_reg;
      memwb_reg_wr_q   <= exmem_reg_wr_q;
      memwb_m2r_q      <= exmem_m2r_q;
      memwb_wr_reg_q   <= exmem_wr_reg_q;
    end
  end

  assign ex_reg_dst     = idex_reg_dst_q;
  assign ex_alu_op      = idex_alu_op_q;
  assign ex_alu_src     = idex_alu_src_q;
  assign ex_branch      = idex_branch_q;
  assign ex_jump        = idex_jump_q;
  assign mem_mem_read   = exmem_mem_read_q;
  assign mem_mem_write  = exmem_mem_wr_q;
  assign mem_reg_write  = exmem_reg_wr_q;
  assign mem_mem_to_reg = exmem_m2r_q;
  assign mem_wr_reg     = exmem_wr_reg_q;
  assign wb_reg_write   = memwb_reg_wr_q;
  assign wb_mem_to_reg  = memwb_m2r_q;
  assign wb_wr_reg      = memwb_wr_reg_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             w_stall_win;

  assign w_stall_win = w_load_use & ~ex_redirect;

  // Saturating event counters: stalls that won priority, and redirect cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_stall_win && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ex_redirect && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe_regs
// Brief    : Directed self-checking bench for ctrl_pipe_regs; counter checks
//            are included when CTRL_PIPE_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_regs;
  localparam int RA_W  = 5;
  localparam int CNT_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [7:0]      id_ctrl;
  logic            id_branch, id_jump;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  logic            ex_redirect;
  logic            pc_write, ifid_write, ifid_flush;
  logic            ex_reg_dst, ex_alu_src, ex_branch, ex_jump;
  logic [1:0]      ex_alu_op;
  logic [RA_W-1:0] ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic            mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
  logic            wb_reg_write, wb_mem_to_reg;
`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  ctrl_pipe_regs #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_branch(id_branch), .id_jump(id_jump), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_redirect(ex_redirect), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .ex_reg_dst(ex_reg_dst),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_wr_reg(ex_wr_reg), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_wr_reg(mem_wr_reg),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_wr_reg(wb_wr_reg)
`ifdef CTRL_PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drive the ID stage.
  task automatic drive(input logic v, input logic [7:0] c, input logic br, input logic jp,
                       input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                       input logic [RA_W-1:0] rd);
    id_valid = v; id_ctrl = c; id_branch = br; id_jump = jp;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_redirect = 1'b0; idle();
    tick();
    checks++;
    if ({ex_reg_dst, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_wr_reg, mem_mem_read,
         mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_wr_reg, wb_reg_write,
         wb_mem_to_reg, wb_wr_reg} !== '0) begin
      failures++; $display("FAIL reset_initial: outputs not all zero during reset");
    end
    @(negedge clk); rst = 1'b0;
    // Fill the pipe with two R-types so EX and MEM are non-zero.
    drive(1'b1, 8'b11000010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3); tick();
    drive(1'b1, 8'b11000010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd4); tick();
    checks++;
    if (ex_wr_reg !== 5'd4 || mem_wr_reg !== 5'd3) begin
      failures++; $display("FAIL reset_prefill: ex_wr_reg=%0d mem_wr_reg=%0d need 4/3", ex_wr_reg, mem_wr_reg);
    end
    // Async reset in mid-cycle: outputs clear without a clock edge.
    #2 rst = 1'b1; #1;
    checks++;
    if ({ex_reg_dst, ex_alu_op, ex_wr_reg, mem_reg_write, mem_wr_reg, wb_reg_write, wb_wr_reg} !== '0) begin
      failures++; $display("FAIL reset_async: ex_wr_reg=%0d mem_wr_reg=%0d wb_wr_reg=%0d need 0",
                           ex_wr_reg, mem_wr_reg, wb_wr_reg);
    end
    idle();
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1 || ifid_flush !== 1'b0) begin
      failures++; $display("FAIL reset_release: pc_write=%b ifid_write=%b ifid_flush=%b need 1/1/0",
                           pc_write, ifid_write, ifid_flush);
    end
  endtask

  task automatic test_rtype_stream();
    drive(1'b1, 8'b11000010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3); tick();
    checks++;
    if (ex_reg_dst !== 1'b1 || ex_alu_op !== 2'b10 || ex_alu_src !== 1'b0 || ex_wr_reg !== 5'd3) begin
      failures++; $display("FAIL rtype_ex: dst=%b op=%b src=%b wr=%0d need 1/10/0/3",
                           ex_reg_dst, ex_alu_op, ex_alu_src, ex_wr_reg);
    end
    idle(); tick();
    checks++;
    if (mem_reg_write !== 1'b1 || mem_wr_reg !== 5'd3 || mem_mem_read !== 1'b0 || ex_reg_dst !== 1'b0) begin
      failures++; $display("FAIL rtype_mem: regwr=%b wr=%0d memrd=%b exdst=%b need 1/3/0/0",
                           mem_reg_write, mem_wr_reg, mem_mem_read, ex_reg_dst);
    end
    tick();
    checks++;
    if (wb_reg_write !== 1'b1 || wb_wr_reg !== 5'd3 || wb_mem_to_reg !== 1'b0) begin
      failures++; $display("FAIL rtype_wb: regwr=%b wr=%0d m2r=%b need 1/3/0",
                           wb_reg_write, wb_wr_reg, wb_mem_to_reg);
    end
    tick();
  endtask

  task automatic test_load_use();
`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] s0;
    s0 = stall_cnt;
`endif
    drive(1'b1, 8'b00011011, 1'b0, 1'b0, 5'd1, 5'd5, 5'd0); tick();
    checks++;
    if (ex_alu_src !== 1'b1 || ex_wr_reg !== 5'd5 || ex_reg_dst !== 1'b0) begin
      failures++; $display("FAIL lw_ex: src=%b wr=%0d dst=%b need 1/5/0", ex_alu_src, ex_wr_reg, ex_reg_dst);
    end
    drive(1'b1, 8'b11000010, 1'b0, 1'b0, 5'd5, 5'd6, 5'd7); #1;
    checks++;
    if (pc_write !== 1'b0 || ifid_write !== 1'b0 || ifid_flush !== 1'b0) begin
      failures++; $display("FAIL lu_stall: pc_write=%b ifid_write=%b flush=%b need 0/0/0",
                           pc_write, ifid_write, ifid_flush);
    end
    tick();
    checks++;
    if ({ex_reg_dst, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_wr_reg} !== '0 ||
        mem_mem_read !== 1'b1 || mem_mem_to_reg !== 1'b1 || mem_wr_reg !== 5'd5) begin
      failures++; $display("FAIL lu_bubble: exdst=%b exwr=%0d memrd=%b m2r=%b memwr=%0d need 0/0/1/1/5",
                           ex_reg_dst, ex_wr_reg, mem_mem_read, mem_mem_to_reg, mem_wr_reg);
    end
    checks++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      failures++; $display("FAIL lu_one_stall: pc_write=%b ifid_write=%b need 1/1", pc_write, ifid_write);
    end
    tick();
    checks++;
    if (ex_reg_dst !== 1'b1 || ex_wr_reg !== 5'd7 || wb_mem_to_reg !== 1'b1 || wb_wr_reg !== 5'd5) begin
      failures++; $display("FAIL lu_resume: exdst=%b exwr=%0d wbm2r=%b wbwr=%0d need 1/7/1/5",
                           ex_reg_dst, ex_wr_reg, wb_mem_to_reg, wb_wr_reg);
    end
`ifdef CTRL_PIPE_PERF_EN
    checks++;
    if (stall_cnt !== s0 + 1'b1) begin
      failures++; $display("FAIL lu_stall_cnt: got %0d need %0d", stall_cnt, s0 + 1'b1);
    end
`endif
    // Load followed by an independent consumer and by a jump: no stall.
    drive(1'b1, 8'b00011011, 1'b0, 1'b0, 5'd1, 5'd5, 5'd0); tick();
    drive(1'b1, 8'b11000010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8); #1;
    checks++;
    if (pc_write !== 1'b1) begin
      failures++; $display("FAIL lu_independent: pc_write=%b need 1", pc_write);
    end
    tick();
    drive(1'b1, 8'b00011011, 1'b0, 1'b0, 5'd1, 5'd9, 5'd0); tick();
    drive(1'b1, 8'b00000000, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0); #1;
    checks++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      failures++; $display("FAIL lu_jump_exempt: pc_write=%b ifid_write=%b need 1/1", pc_write, ifid_write);
    end
    tick();
    checks++;
    if (ex_jump !== 1'b1) begin
      failures++; $display("FAIL jump_ex: ex_jump=%b need 1", ex_jump);
    end
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_flush_over_stall();
`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] s0, f0;
`endif
    drive(1'b1, 8'b00011011, 1'b0, 1'b0, 5'd1, 5'd5, 5'd0); tick();
`ifdef CTRL_PIPE_PERF_EN
    s0 = stall_cnt; f0 = flush_cnt;
`endif
    drive(1'b1, 8'b11000010, 1'b0, 1'b0, 5'd5, 5'd6, 5'd7);
    ex_redirect = 1'b1; #1;
    checks++;
    if (ifid_flush !== 1'b1 || pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      failures++; $display("FAIL flush_ctrl: flush=%b pc_write=%b ifid_write=%b need 1/1/1",
                           ifid_flush, pc_write, ifid_write);
    end
    tick();
    ex_redirect = 1'b0; idle();
    checks++;
    if ({ex_reg_dst, ex_alu_op, ex_alu_src, ex_wr_reg} !== '0) begin
      failures++; $display("FAIL flush_bubble: exdst=%b exop=%b exwr=%0d need 0/00/0",
                           ex_reg_dst, ex_alu_op, ex_wr_reg);
    end
`ifdef CTRL_PIPE_PERF_EN
    checks++;
    if (flush_cnt !== f0 + 1'b1 || stall_cnt !== s0) begin
      failures++; $display("FAIL flush_cnts: flush=%0d stall=%0d need %0d/%0d",
                           flush_cnt, stall_cnt, f0 + 1'b1, s0);
    end
`endif
    tick(); tick(); tick();
  endtask

  task automatic test_zero_write();
    drive(1'b1, 8'b00010010, 1'b0, 1'b0, 5'd4, 5'd0, 5'd9); tick();
    idle();
    checks++;
    if (ex_wr_reg !== 5'd0 || ex_alu_src !== 1'b1) begin
      failures++; $display("FAIL zero_ex: wr=%0d src=%b need 0/1", ex_wr_reg, ex_alu_src);
    end
    tick();
    checks++;
    if (mem_reg_write !== 1'b0) begin
      failures++; $display("FAIL zero_mem: mem_reg_write=%b need 0", mem_reg_write);
    end
    tick();
    checks++;
    if (wb_reg_write !== 1'b0) begin
      failures++; $display("FAIL zero_wb: wb_reg_write=%b need 0", wb_reg_write);
    end
    tick();
  endtask

  task automatic test_sw_dont_care();
    drive(1'b1, 8'bx001010x, 1'b0, 1'b0, 5'd1, 5'd4, 5'bxxxxx); tick();
    idle();
    checks++;
    if (ex_reg_dst !== 1'b0 || ex_alu_src !== 1'b1 || ex_alu_op !== 2'b00 || ex_wr_reg !== 5'd4) begin
      failures++; $display("FAIL sw_ex: dst=%b src=%b op=%b wr=%0d need 0/1/00/4",
                           ex_reg_dst, ex_alu_src, ex_alu_op, ex_wr_reg);
    end
    tick();
    checks++;
    if (mem_mem_write !== 1'b1 || mem_mem_to_reg !== 1'b0 || mem_reg_write !== 1'b0) begin
      failures++; $display("FAIL sw_mem: memwr=%b m2r=%b regwr=%b need 1/0/0",
                           mem_mem_write, mem_mem_to_reg, mem_reg_write);
    end
    checks++;
    if ($isunknown({pc_write, ifid_write, ifid_flush, ex_reg_dst, ex_alu_op, ex_alu_src,
                    ex_branch, ex_jump, ex_wr_reg, mem_mem_read, mem_mem_write,
                    mem_reg_write, mem_mem_to_reg, mem_wr_reg, wb_reg_write,
                    wb_mem_to_reg, wb_wr_reg})) begin
      failures++; $display("FAIL sw_no_x: unknown value on an output, need all known");
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'b11000010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10); tick();
    drive(1'b1, 8'b00000000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0); tick();
    checks++;
    if (ex_branch !== 1'b1 || ex_wr_reg !== 5'd2 || mem_wr_reg !== 5'd10 || mem_reg_write !== 1'b1) begin
      failures++; $display("FAIL b2b: exbr=%b exwr=%0d memwr=%0d memregwr=%b need 1/2/10/1",
                           ex_branch, ex_wr_reg, mem_wr_reg, mem_reg_write);
    end
    idle(); tick();
    checks++;
    if (mem_reg_write !== 1'b0 || wb_wr_reg !== 5'd10 || ex_branch !== 1'b0) begin
      failures++; $display("FAIL b2b_next: memregwr=%b wbwr=%0d exbr=%b need 0/10/0",
                           mem_reg_write, wb_wr_reg, ex_branch);
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_rtype_stream();
    test_load_use();
    test_flush_over_stall();
    test_zero_write();
    test_sw_dont_care();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
